// File: rtl/posit_pkg.sv
// Posit<32,3> field constants, FSM encoding and body helper shared by
// posit_decoder, exp_adder and the fraction multiplier.
package posit_pkg;

   localparam int N      = 32;
   localparam int ES     = 3;
   localparam int K_BITS = 6;
   localparam int FRAC_W = N - 3 - ES;
   localparam int BODY_W = N - 1;
   localparam int REST_W = ES + FRAC_W;

   localparam logic [N-1:0] ZERO_WORD = '0;
   localparam logic [N-1:0] NAR_WORD  = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COUNT,
      S_EXTRACT,
      S_DONE
   } state_t;

   // Negative posits are decoded from the magnitude of the word.
   function automatic logic [BODY_W-1:0] posit_body(
      input logic [N-1:0] w
   );
      return w[N-1] ? BODY_W'(~w + 1'b1) : w[BODY_W-1:0];
   endfunction

endpackage

// File: rtl/posit_regime_counter.sv
// Regime run-length datapath: serial 1 bit/cycle shift counter, or a
// single-cycle leading-run detector under POSIT_DEC_FAST_REGIME_EN.
module posit_regime_counter
   import posit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [BODY_W-1:0] body,
   output logic [K_BITS-1:0] m,
   output logic              r0,
   output logic              last,
   output logic [REST_W-1:0] rest
);

   localparam logic [K_BITS-1:0] M_LAST = K_BITS'(BODY_W);

   logic [BODY_W-1:0] sh;

`ifdef POSIT_DEC_FAST_REGIME_EN

   logic [K_BITS-1:0] run;
   logic              stop;

   always_comb begin
      run  = '0;
      stop = 1'b0;
      for (int i = BODY_W-1; i >= 0; i--) begin
         if (!stop && body[i] == body[BODY_W-1])
            run = run + 1'b1;
         else
            stop = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh <= '0;
         m  <= '0;
         r0 <= 1'b0;
      end else if (load) begin
         sh <= body << run;
         m  <= run;
         r0 <= body[BODY_W-1];
      end
   end

   assign last = step;

`else

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh <= '0;
         m  <= '0;
         r0 <= 1'b0;
      end else if (load) begin
         sh <= body;
         m  <= '0;
         r0 <= body[BODY_W-1];
      end else if (step) begin
         sh <= sh << 1;
         m  <= m + 1'b1;
      end
   end

   // Stop once the bit that follows the one being consumed breaks the run.
   assign last = step &&
                 ((m + 1'b1 == M_LAST) ||
                  (sh[BODY_W-2] != r0));

`endif

   // A full-width run has no terminator bit to skip.
   assign rest = (m == M_LAST) ?
                 sh[BODY_W-1 -: REST_W] :
                 sh[BODY_W-2 -: REST_W];

endmodule

// File: rtl/posit_decoder.sv
// Multi-cycle posit field extractor with start/done/ack handshake.
// Define POSIT_DEC_FAST_REGIME_EN for a one-cycle regime count.
module posit_decoder
   import posit_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [N-1:0]      posit_in,
   input  logic              ack,
   output logic              busy,
   output logic              done,
   output logic              sign_out,
   output logic [K_BITS-1:0] k_out,
   output logic [ES-1:0]     exp_out,
   output logic [FRAC_W-1:0] frac_out,
   output logic              zero_out,
   output logic              nar_out
);

   state_t state;
   state_t state_nx;

   logic [N-1:0]      word;
   logic [BODY_W-1:0] body;
   logic              special;
   logic [K_BITS-1:0] m;
   logic              r0;
   logic              last;
   logic [REST_W-1:0] rest;

   assign body    = posit_body(word);
   assign special = (word == ZERO_WORD) ||
                    (word == NAR_WORD);

   posit_regime_counter u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .load (state == S_LOAD),
      .step (state == S_COUNT),
      .body (body),
      .m    (m),
      .r0   (r0),
      .last (last),
      .rest (rest)
   );

   // Zero/NaR still pass through EXTRACT so every result
   // leaves through the same DONE entry path.
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:    if (start) state_nx = S_LOAD;
         S_LOAD:    state_nx = special ? S_EXTRACT : S_COUNT;
         S_COUNT:   if (last) state_nx = S_EXTRACT;
         S_EXTRACT: state_nx = S_DONE;
         S_DONE:    if (ack) state_nx = S_IDLE;
         default:   state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         word     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sign_out <= 1'b0;
         k_out    <= '0;
         exp_out  <= '0;
         frac_out <= '0;
         zero_out <= 1'b0;
         nar_out  <= 1'b0;
      end else begin
         state <= state_nx;
         busy  <= (state_nx != S_IDLE);
         done  <= (state_nx == S_DONE);
         if (state == S_IDLE && start)
            word <= posit_in;
         if (state == S_LOAD) begin
            sign_out <= word[N-1];
            zero_out <= (word == ZERO_WORD);
            nar_out  <= (word == NAR_WORD);
            k_out    <= '0;
            exp_out  <= '0;
            frac_out <= '0;
         end
         if (state == S_EXTRACT && !special) begin
            k_out    <= r0 ? m - 1'b1 : -m;
            exp_out  <= rest[REST_W-1 -: ES];
            frac_out <= rest[FRAC_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_posit_decoder.sv
// Scoreboard bench for posit_decoder: directed vectors with hand-computed
// fields; latency expectations follow POSIT_DEC_FAST_REGIME_EN.
module tb_posit_decoder;

`ifdef POSIT_DEC_FAST_REGIME_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] posit_in;
   logic        ack;
   logic        busy;
   logic        done;
   logic        sign_out;
   logic [5:0]  k_out;
   logic [2:0]  exp_out;
   logic [25:0] frac_out;
   logic        zero_out;
   logic        nar_out;

   posit_decoder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .posit_in(posit_in),
      .ack     (ack),
      .busy    (busy),
      .done    (done),
      .sign_out(sign_out),
      .k_out   (k_out),
      .exp_out (exp_out),
      .frac_out(frac_out),
      .zero_out(zero_out),
      .nar_out (nar_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] w;
      logic        s;
      logic [5:0]  k;
      logic [2:0]  e;
      logic [25:0] f;
      logic        z;
      logic        n;
      int          m;
   } vec_t;

   typedef struct {
      logic        s;
      logic [5:0]  k;
      logic [2:0]  e;
      logic [25:0] f;
      logic        z;
      logic        n;
      int          lat;
   } exp_t;

   exp_t q[$];
   vec_t vecs[13];
   int   passed = 0;
   int   total  = 0;
   int   cyc    = 0;
   int   t_start = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, want %0h", name, act, req);
   endtask

   function automatic logic [63:0] pack_out();
      return 64'({sign_out, k_out, exp_out, frac_out, zero_out, nar_out});
   endfunction

   function automatic logic [63:0] pack_exp(input exp_t e);
      return 64'({e.s, e.k, e.e, e.f, e.z, e.n});
   endfunction

   // Monitor: pops one expectation on each rising done.
   initial begin
      exp_t cur;
      bit   got;
      got = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            got = 1'b0;
         end else if (done && !got) begin
            got = 1'b1;
            if (q.size() == 0) begin
               total++;
               $display("FAIL spurious_done: got done=1, want no result");
            end else begin
               cur = q.pop_front();
               chk("sign", 64'(sign_out), 64'(cur.s));
               chk("k",    64'(k_out),    64'(cur.k));
               chk("exp",  64'(exp_out),  64'(cur.e));
               chk("frac", 64'(frac_out), 64'(cur.f));
               chk("zero", 64'(zero_out), 64'(cur.z));
               chk("nar",  64'(nar_out),  64'(cur.n));
               chk("latency", 64'(cyc - t_start), 64'(cur.lat));
            end
         end else if (done && got && ack) begin
            chk("hold", pack_out(), pack_exp(cur));
         end else if (!done) begin
            got = 1'b0;
         end
      end
   end

   task automatic run_vec(input vec_t v, input int hold);
      exp_t e;
      bit   seen;
      e.s = v.s;
      e.k = v.k;
      e.e = v.e;
      e.f = v.f;
      e.z = v.z;
      e.n = v.n;
      e.lat = (v.z || v.n) ? 2 : (FAST ? 3 : v.m + 2);
      @(posedge clk); #1;
      q.push_back(e);
      start    = 1'b1;
      posit_in = v.w;
      @(posedge clk); #1;
      t_start  = cyc;
      start    = 1'b0;
      posit_in = 32'h0;
      seen     = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk); #1;
         if (i == 0 && !done) chk("busy", 64'(busy), 64'd1);
         // Pulse start once mid-operation; it must be ignored.
         start    = (i == 0) && !done;
         posit_in = start ? 32'h5A5A1234 : 32'h0;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!seen) begin
         total++;
         $display("FAIL timeout: got no done, want done for %0h", v.w);
         rst_n = 1'b0;
         q.delete();
         @(posedge clk); #1;
         rst_n = 1'b1;
      end else begin
         repeat (hold) begin
            @(posedge clk); #1;
         end
         ack      = 1'b1;
         start    = 1'b1;
         posit_in = 32'h40000000;
         @(posedge clk); #1;
         ack   = 1'b0;
         start = 1'b0;
         chk("ack_start", 64'({busy, done}), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{32'h40000000, 1'b0, 6'd0,  3'd0, 26'h0,       1'b0, 1'b0, 1};
      vecs[1]  = '{32'h48000000, 1'b0, 6'd0,  3'd2, 26'h0,       1'b0, 1'b0, 1};
      vecs[2]  = '{32'hC0000000, 1'b1, 6'd0,  3'd0, 26'h0,       1'b0, 1'b0, 1};
      vecs[3]  = '{32'h00000000, 1'b0, 6'd0,  3'd0, 26'h0,       1'b1, 1'b0, 0};
      vecs[4]  = '{32'h80000000, 1'b1, 6'd0,  3'd0, 26'h0,       1'b0, 1'b1, 0};
      vecs[5]  = '{32'h7FFFFFFF, 1'b0, 6'd30, 3'd0, 26'h0,       1'b0, 1'b0, 31};
      vecs[6]  = '{32'h00000001, 1'b0, 6'h22, 3'd0, 26'h0,       1'b0, 1'b0, 30};
      vecs[7]  = '{32'h7FFFFFFE, 1'b0, 6'd29, 3'd0, 26'h0,       1'b0, 1'b0, 30};
      vecs[8]  = '{32'h0C000000, 1'b0, 6'h3D, 3'd4, 26'h0,       1'b0, 1'b0, 3};
      vecs[9]  = '{32'h4FFFFFFF, 1'b0, 6'd0,  3'd3, 26'h3FFFFFF, 1'b0, 1'b0, 1};
      vecs[10] = '{32'h60000001, 1'b0, 6'd1,  3'd0, 26'h2,       1'b0, 1'b0, 2};
      vecs[11] = '{32'h3A000000, 1'b0, 6'h3F, 3'd6, 26'h2000000, 1'b0, 1'b0, 1};
      vecs[12] = '{32'hFFFFFFFF, 1'b1, 6'h22, 3'd0, 26'h0,       1'b0, 1'b0, 30};

      rst_n    = 1'b0;
      start    = 1'b0;
      ack      = 1'b0;
      posit_in = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", pack_out(), 64'd0);
      chk("reset_hs", 64'({busy, done}), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++)
         run_vec(vecs[i], (i == 0) ? 10 : 1 + (i % 3));

      // Reset while the regime is being counted.
      @(posedge clk); #1;
      start    = 1'b1;
      posit_in = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("pre_reset", 64'({busy, sign_out}), 64'd3);
      rst_n = 1'b0;
      #1;
      chk("async_reset", pack_out(), 64'd0);
      chk("async_reset_hs", 64'({busy, done}), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_vec(vecs[11], 2);
      run_vec(vecs[4], 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
